// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
//   Sequencer for the AES round-key expander. It loads the key, steps the
//   expander and publishes which round key is on the expander output, so the
//   cipher datapath can take one round key per cycle:
//     INV=0 (encrypt): rounds 0..NR
//     INV=1 (decrypt): rounds NR..0
//   NR = 10/12/14 for K = 128/192/256.
//   For INV=1 the expander first runs forward NR steps (FWD) to reach the last
//   key, then reverses direction and emits keys NR..0.
//
// Handshake: a request is taken when i_start=1 in a cycle where o_ready=1 and
//   i_abort=0. While o_ready=0, i_start is ignored and not remembered. i_abort
//   cancels any schedule in progress; the controller is back in IDLE the next
//   cycle, and no o_rk_last is produced.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   i_start      in   request a new schedule
//   i_abort      in   cancel the current schedule
//   o_ready      out  1 in IDLE
//   o_key_load   out  expander reset/load (reset | state==LOAD), combinational
//   o_done1      out  expander done1 (INV=0: freeze; INV=1: reverse direction)
//   o_done2      out  expander done2 (INV=1 freeze); 0 when INV=0
//   o_predone    out  expander predone, last FWD step for K=192/256, INV=1
//   o_rk_valid   out  expander output is round key o_round this cycle
//   o_round      out  round index of the current key
//   o_rk_last    out  with o_rk_valid: final key of the schedule
//   o_dbg_state  out  current FSM state (IDLE=0, LOAD=1, FWD=2, RUN=3)
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl #(
  parameter int K   = 128,
  parameter bit INV = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_ready,
  output logic       o_key_load,
  output logic       o_done1,
  output logic       o_done2,
  output logic       o_predone,
  output logic       o_rk_valid,
  output logic [3:0] o_round,
  output logic       o_rk_last,
  output logic [1:0] o_dbg_state
);

  localparam int         NR_I  = (K == 256) ? 14 : (K == 192) ? 12 : 10;
  localparam logic [3:0] NR    = 4'(NR_I);
  localparam logic [3:0] NR_M1 = 4'(NR_I - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FWD  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;

  state_t     w_next_state;
  logic [3:0] w_next_cnt;

  logic       r_ready, r_done1, r_done2, r_predone, r_rk_valid, r_rk_last;
  logic [3:0] r_round;

  logic       w_ready, w_done1, w_done2, w_predone, w_rk_valid, w_rk_last;
  logic [3:0] w_round;
  logic       w_term;

  // Next state / counter. r_cnt is the FWD step c in FWD and the round index
  // in RUN; the terminal values force the exit, so it never wraps.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // abort has priority over start
        if (i_start && !i_abort) begin
          w_next_state = S_LOAD;
          w_next_cnt   = 4'd0;
        end
      end
      S_LOAD: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
          w_next_cnt   = 4'd0;
        end else if (INV) begin
          w_next_state = S_FWD;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_state = S_RUN;
          w_next_cnt   = 4'd0;
        end
      end
      S_FWD: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
          w_next_cnt   = 4'd0;
        end else if (r_cnt == NR_M1) begin
          // expander now holds the final key; emit it first
          w_next_state = S_RUN;
          w_next_cnt   = NR;
        end else begin
          w_next_cnt   = r_cnt + 4'd1;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
          w_next_cnt   = 4'd0;
        end else if (INV ? (r_cnt == 4'd0) : (r_cnt == NR)) begin
          w_next_state = S_IDLE;
          w_next_cnt   = 4'd0;
        end else if (INV) begin
          w_next_cnt   = r_cnt - 4'd1;
        end else begin
          w_next_cnt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Output decode of the next state, so the registered outputs line up with
  // the state they describe.
  always_comb begin
    w_ready    = (w_next_state == S_IDLE);
    w_rk_valid = (w_next_state == S_RUN);
    w_round    = w_rk_valid ? w_next_cnt : 4'd0;
    w_term     = INV ? (w_next_cnt == 4'd0) : (w_next_cnt == NR);
    w_rk_last  = w_rk_valid && w_term;
    w_predone  = INV && (K != 128) && (w_next_state == S_FWD) &&
                 (w_next_cnt == NR_M1);
    if (INV) begin
      // done1 low only while stepping forward; done2 freezes in IDLE/LOAD
      // and on the final (round 0) key
      w_done1 = (w_next_state != S_FWD);
      w_done2 = (w_next_state == S_IDLE) || (w_next_state == S_LOAD) ||
                (w_rk_valid && (w_next_cnt == 4'd0));
    end else begin
      // hold the expander on the last key (round NR)
      w_done1 = !w_rk_valid || (w_next_cnt == NR);
      w_done2 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_ready    <= 1'b1;
      r_done1    <= 1'b1;
      r_done2    <= INV;
      r_predone  <= 1'b0;
      r_rk_valid <= 1'b0;
      r_round    <= 4'd0;
      r_rk_last  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_ready    <= w_ready;
      r_done1    <= w_done1;
      r_done2    <= w_done2;
      r_predone  <= w_predone;
      r_rk_valid <= w_rk_valid;
      r_round    <= w_round;
      r_rk_last  <= w_rk_last;
    end
  end

  assign o_key_load  = reset | (r_state == S_LOAD);
  assign o_ready     = r_ready;
  assign o_done1     = r_done1;
  assign o_done2     = r_done2;
  assign o_predone   = r_predone;
  assign o_rk_valid  = r_rk_valid;
  assign o_round     = r_round;
  assign o_rk_last   = r_rk_last;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
//   Three controllers share clk/reset/start/abort:
//     u0: K=128 INV=0, u1: K=256 INV=1, u2: K=192 INV=1.
//   Each is compared every cycle against a timeline model: a busy flag and the
//   number of cycles since the start was taken, from which every output is
//   derived. Directed sequences pin exact cycles with literal values; a random
//   phase exercises start/abort/reset interleavings. u0's round sequence is
//   also tracked through an expected queue.
// -----------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort;

  logic       rdy[3], kl[3], d1[3], d2[3], pd[3], vld[3], lst[3];
  logic [3:0] rnd[3];
  logic [1:0] dbg[3];

  aes_key_sched_ctrl #(.K(128), .INV(1'b0)) u0 (
    .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
    .o_ready(rdy[0]), .o_key_load(kl[0]), .o_done1(d1[0]), .o_done2(d2[0]),
    .o_predone(pd[0]), .o_rk_valid(vld[0]), .o_round(rnd[0]),
    .o_rk_last(lst[0]), .o_dbg_state(dbg[0]));

  aes_key_sched_ctrl #(.K(256), .INV(1'b1)) u1 (
    .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
    .o_ready(rdy[1]), .o_key_load(kl[1]), .o_done1(d1[1]), .o_done2(d2[1]),
    .o_predone(pd[1]), .o_rk_valid(vld[1]), .o_round(rnd[1]),
    .o_rk_last(lst[1]), .o_dbg_state(dbg[1]));

  aes_key_sched_ctrl #(.K(192), .INV(1'b1)) u2 (
    .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
    .o_ready(rdy[2]), .o_key_load(kl[2]), .o_done1(d1[2]), .o_done2(d2[2]),
    .o_predone(pd[2]), .o_rk_valid(vld[2]), .o_round(rnd[2]),
    .o_rk_last(lst[2]), .o_dbg_state(dbg[2]));

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_inv[3] = '{0, 1, 1};
  int m_nr[3]  = '{10, 14, 12};
  int m_k[3]   = '{128, 256, 192};
  bit m_busy[3] = '{0, 0, 0};
  int m_t[3]    = '{0, 0, 0};

  // Last timeline step of a schedule: LOAD at t=1, then NR+1 keys (INV=0) or
  // NR forward steps plus NR+1 keys (INV=1).
  function automatic int m_last(input int i);
    return (m_inv[i] != 0) ? 2 * m_nr[i] + 2 : m_nr[i] + 2;
  endfunction

  // {ready, key_load, done1, done2, predone, rk_valid, round[3:0], rk_last}
  function automatic logic [10:0] exp_vec(input int i, input logic rst);
    bit rdy_e, kl_e, d1_e, d2_e, pd_e, v_e, l_e, fwd;
    int r_e;
    rdy_e = !m_busy[i];
    kl_e  = rst || (m_busy[i] && m_t[i] == 1);
    if (m_inv[i] == 0) begin
      v_e  = m_busy[i] && m_t[i] >= 2;
      r_e  = v_e ? m_t[i] - 2 : 0;
      l_e  = v_e && r_e == m_nr[i];
      d1_e = !(v_e && r_e < m_nr[i]);
      d2_e = 1'b0;
      pd_e = 1'b0;
    end else begin
      fwd  = m_busy[i] && m_t[i] >= 2 && m_t[i] <= m_nr[i] + 1;
      v_e  = m_busy[i] && m_t[i] >= m_nr[i] + 2;
      r_e  = v_e ? 2 * m_nr[i] + 2 - m_t[i] : 0;
      l_e  = v_e && r_e == 0;
      d1_e = !fwd;
      d2_e = !fwd && (!v_e || r_e == 0);
      pd_e = fwd && (m_t[i] == m_nr[i] + 1) && (m_k[i] != 128);
    end
    return {rdy_e, kl_e, d1_e, d2_e, pd_e, v_e, r_e[3:0], l_e};
  endfunction

  // scoreboard of u0 round indices still to be emitted
  logic [3:0] exp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || (m_busy[0] && abort)) begin
      exp_q.delete();
    end else if (!m_busy[0] && start && !abort) begin
      for (int r = 0; r <= 10; r++) exp_q.push_back(4'(r));
    end
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_busy[i] <= 1'b0;
        m_t[i]    <= 0;
      end else if (m_busy[i]) begin
        if (abort || m_t[i] == m_last(i)) begin
          m_busy[i] <= 1'b0;
          m_t[i]    <= 0;
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end else if (start && !abort) begin
        m_busy[i] <= 1'b1;
        m_t[i]    <= 1;
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model u%0d cyc %0d", i, cyc),
            {21'd0, rdy[i], kl[i], d1[i], d2[i], pd[i], vld[i], rnd[i], lst[i]},
            {21'd0, exp_vec(i, reset)});
      end
      if (vld[0]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb u0 unexpected key: got round %0d expected none", rnd[0]);
        end else begin
          chk($sformatf("sb u0 round cyc %0d", cyc), {28'd0, rnd[0]}, {28'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Drives the inputs for the next cycle and returns at that cycle's negedge.
  task automatic cyc_step(input logic s, input logic a, input logic r);
    @(posedge clk);
    #1;
    start = s;
    abort = a;
    reset = r;
    @(negedge clk);
  endtask

  int c_pd1, c_pd2, c_f1, c_f2, c_v0, c_v2, c_kl, c_v1, c_l1, c_l0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    chk("reset u0 ready", {31'd0, rdy[0]}, 32'd1);
    chk("reset u1 done2", {31'd0, d2[1]}, 32'd1);
    chk("reset u0 done2", {31'd0, d2[0]}, 32'd0);

    // ---- full schedules from one start at cycle 0 ----
    cyc_step(1, 0, 0);
    c_pd1 = 0; c_pd2 = 0; c_f1 = 0; c_f2 = 0; c_v0 = 0; c_v2 = 0;
    for (int n = 1; n <= 32; n++) begin
      cyc_step(0, 0, 0);
      c_pd1 += int'(pd[1]);
      c_pd2 += int'(pd[2]);
      c_f1  += int'(!d1[1]);
      c_f2  += int'(!d1[2]);
      c_v0  += int'(vld[0]);
      c_v2  += int'(vld[2]);
      if (n == 1) begin
        chk("t1 u0 key_load c1", {31'd0, kl[0]}, 32'd1);
        chk("t1 u1 key_load c1", {31'd0, kl[1]}, 32'd1);
      end
      if (n == 2) chk("t1 u0 first key", {27'd0, vld[0], rnd[0]}, 32'h10);
      if (n == 12) chk("t1 u0 last key", {26'd0, vld[0], lst[0], rnd[0]}, 32'h3a);
      if (n == 13) begin
        chk("t1 u0 ready c13", {31'd0, rdy[0]}, 32'd1);
        chk("t1 u2 predone c13", {31'd0, pd[2]}, 32'd1);
      end
      if (n == 15) chk("t1 u1 predone c15", {31'd0, pd[1]}, 32'd1);
      if (n == 16) chk("t1 u1 first key", {27'd0, vld[1], rnd[1]}, 32'h1e);
      if (n == 26) chk("t1 u2 last key", {26'd0, vld[2], lst[2], rnd[2]}, 32'h30);
      if (n == 30) chk("t1 u1 last key", {25'd0, vld[1], lst[1], d2[1], rnd[1]}, 32'h70);
      if (n == 31) chk("t1 u1 ready c31", {31'd0, rdy[1]}, 32'd1);
    end
    chk("t1 u1 predone pulses", c_pd1, 1);
    chk("t1 u2 predone pulses", c_pd2, 1);
    chk("t1 u1 fwd cycles", c_f1, 14);
    chk("t1 u2 fwd cycles", c_f2, 12);
    chk("t1 u0 key count", c_v0, 11);
    chk("t1 u2 key count", c_v2, 13);

    // ---- start held high ----
    cyc_step(0, 0, 1);
    cyc_step(0, 0, 0);
    cyc_step(1, 0, 0);
    c_kl = 0;
    for (int n = 1; n <= 26; n++) begin
      cyc_step(1, 0, 0);
      c_kl += int'(kl[0]);
      if (n == 13) chk("t2 u0 ready c13", {31'd0, rdy[0]}, 32'd1);
      if (n == 14) chk("t2 u0 key_load c14", {31'd0, kl[0]}, 32'd1);
    end
    chk("t2 u0 key_load pulses", c_kl, 2);
    cyc_step(0, 0, 1);
    cyc_step(0, 0, 0);

    // ---- abort in FWD at c=5 (cycle 7) ----
    cyc_step(1, 0, 0);
    c_v1 = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc_step(0, n == 7, 0);
      c_v1 += int'(vld[1]);
      if (n == 7) chk("t3 u1 in fwd c7", {31'd0, d1[1]}, 32'd0);
      if (n == 8) begin
        chk("t3 u1 idle after abort", {30'd0, rdy[1], vld[1]}, 32'd2);
        chk("t3 u0 idle after abort", {30'd0, rdy[0], lst[0]}, 32'd2);
      end
    end
    chk("t3 u1 no keys", c_v1, 0);
    cyc_step(1, 0, 0);
    c_v1 = 0; c_l1 = 0;
    for (int n = 1; n <= 32; n++) begin
      cyc_step(0, 0, 0);
      c_v1 += int'(vld[1]);
      c_l1 += int'(lst[1]);
      if (n == 16) chk("t3 u1 restart first key", {28'd0, rnd[1]}, 32'd14);
    end
    chk("t3 u1 restart key count", c_v1, 15);
    chk("t3 u1 restart last count", c_l1, 1);

    // ---- reset at RUN round 3, then abort+start together ----
    cyc_step(1, 0, 0);
    c_l0 = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc_step(n == 7, n == 7, n == 5);
      c_l0 += int'(lst[0]);
      if (n == 5) chk("t4 u0 round3 with reset", {27'd0, kl[0], rnd[0]}, 32'h13);
      if (n == 6) chk("t4 u0 idle after reset", {29'd0, rdy[0], vld[0], kl[0]}, 32'h4);
      if (n == 8) begin
        chk("t4 u0 idle after abort+start", {30'd0, rdy[0], kl[0]}, 32'h2);
        chk("t4 u2 idle after abort+start", {31'd0, rdy[2]}, 32'd1);
      end
    end
    chk("t4 u0 no rk_last", c_l0, 0);

    // ---- random interleaving ----
    for (int n = 0; n < 3000; n++) begin
      cyc_step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 199) == 0);
    end
    for (int n = 0; n < 40; n++) cyc_step(0, 0, 0);
    chk("sb queue drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
